load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 122 ++++++++++++
 tb/tb_load_store_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: single outstanding access with byte/half/word lanes and load extension.
// Optional LSU_MISALIGN_TRAP_EN: misaligned H/W accesses complete without a memory request and flag misalign_o.
module load_store_unit (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        done_o,
  output logic        misalign_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      r_state;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_mis;

  logic        w_byte;
  logic        w_half;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shift;
  logic [31:0] w_load;
  logic        w_trap;

  assign w_byte = (r_f3[1:0] == 2'b00);
  assign w_half = (r_f3[1:0] == 2'b01);

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_in_half;
  logic w_in_word;
  assign w_in_half = (funct3_i[1:0] == 2'b01);
  assign w_in_word = funct3_i[1];
  assign w_trap    = (w_in_half & addr_i[0]) | (w_in_word & (|addr_i[1:0]));
`else
  assign w_trap    = 1'b0;
`endif

  // Low address bits below the access size are ignored, so misaligned H/W fall back to the aligned lane.
  always_comb begin
    w_off   = 2'b00;
    w_be    = 4'b1111;
    w_wdata = r_wdata;
    if (w_byte) begin
      w_off   = r_addr[1:0];
      w_be    = 4'b0001 << r_addr[1:0];
      w_wdata = {4{r_wdata[7:0]}};
    end else if (w_half) begin
      w_off   = {r_addr[1], 1'b0};
      w_be    = 4'b0011 << {r_addr[1], 1'b0};
      w_wdata = {2{r_wdata[15:0]}};
    end
  end

  always_comb begin
    w_shift = mem_rdata_i >> {w_off, 3'b000};
    w_load  = w_shift;
    if (w_byte)
      w_load = {{24{w_shift[7] & ~r_f3[2]}}, w_shift[7:0]};
    else if (w_half)
      w_load = {{16{w_shift[15] & ~r_f3[2]}}, w_shift[15:0]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_f3    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_mis   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start_i) begin
          r_we    <= we_i;
          r_f3    <= funct3_i;
          r_addr  <= addr_i;
          r_wdata <= wdata_i;
          r_mis   <= w_trap;
          r_state <= w_trap ? DONE : REQ;
        end
        REQ:  if (mem_gnt_i) r_state <= r_we ? DONE : WAIT;
        WAIT: if (mem_rvalid_i) begin
          r_rdata <= w_load;
          r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_req_o   = (r_state == REQ);
  assign mem_we_o    = mem_req_o & r_we;
  assign mem_addr_o  = {r_addr[31:2], 2'b00};
  assign mem_be_o    = mem_req_o ? w_be : '0;
  assign mem_wdata_o = w_wdata;
  assign done_o      = (r_state == DONE);
  assign misalign_o  = done_o & r_mis;
  assign rdata_o     = r_rdata;
  // Gated by reset so a held-high start_i cannot raise stall while the unit is in reset.
  assign stall_o     = rst_ni & (((r_state == IDLE) & start_i) | (r_state == REQ) | (r_state == WAIT));

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit; expected responses come from a byte-level reference model.
module tb_load_store_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i, we_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i;
  logic [31:0] rdata_o;
  logic        stall_o, done_o, misalign_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  load_store_unit dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .we_i(we_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .stall_o(stall_o), .done_o(done_o),
    .misalign_o(misalign_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { int unsigned cyc; logic mis; logic [31:0] rdata; } done_t;
  typedef struct { logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; logic we; } req_t;

  done_t       done_q[$];
  req_t        req_q[$];
  int unsigned cyc = 0;
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  logic [31:0] last_load = '0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Done/result monitor
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && done_o === 1'b1) begin
      if (done_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        done_t e;
        e = done_q.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("misalign", {31'd0, misalign_o}, {31'd0, e.mis});
        chk("rdata", rdata_o, e.rdata);
      end
    end
  end

  // Memory request monitor
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && mem_req_o === 1'b1 && mem_gnt_i === 1'b1) begin
      if (req_q.size() == 0) chk("unexpected_req", 32'd1, 32'd0);
      else begin
        req_t r;
        r = req_q.pop_front();
        chk("mem_addr", mem_addr_o, r.addr);
        chk("mem_be", {28'd0, mem_be_o}, {28'd0, r.be});
        chk("mem_wdata", mem_wdata_o, r.wdata);
        chk("mem_we", {31'd0, mem_we_o}, {31'd0, r.we});
      end
    end
  end

  function automatic int unsigned acc_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] mword,
                         input int unsigned gdly, input int unsigned rdly);
    int unsigned sz, base, k;
    logic        mis, trap;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [63:0] v;
    done_t       d;
    req_t        r;
    sz   = acc_size(f3);
    mis  = (int'(addr[1:0]) % sz) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = mis;
`else
    trap = 1'b0;
`endif
    base = (int'(addr[1:0]) / sz) * sz;
    for (int i = 0; i < 4; i++) begin
      be[i] = (i >= base) && (i < base + sz);
      wd[8*i +: 8] = wdata[8*(i % sz) +: 8];
    end
    v = '0;
    for (int j = 0; j < sz; j++) v = v | (64'(mword[8*(base+j) +: 8]) << (8*j));
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v - (64'd1 << (8*sz));
    if (!we && !trap) last_load = v[31:0];

    k = cyc;
    d.cyc   = trap ? k + 1 : (we ? k + 2 + gdly : k + 3 + gdly + rdly);
    d.mis   = trap;
    d.rdata = last_load;
    done_q.push_back(d);
    if (!trap) begin
      r.addr = {addr[31:2], 2'b00}; r.be = be; r.wdata = wd; r.we = we;
      req_q.push_back(r);
    end

    start_i = 1'b1; we_i = we; funct3_i = f3; addr_i = addr; wdata_i = wdata;
    #2 chk("stall_idle_start", {31'd0, stall_o}, 32'd1);
    @(posedge clk_i); #1;
    start_i = 1'b0; we_i = $urandom % 2; funct3_i = 3'($urandom);
    addr_i = $urandom; wdata_i = $urandom;
    if (!trap) begin
      for (int i = 0; i < gdly; i++) begin
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'($urandom % 2); mem_rdata_i = $urandom;
        #1 chk("stall_req", {31'd0, stall_o}, 32'd1);
        @(posedge clk_i); #1;
      end
      mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0;
      @(posedge clk_i); #1;
      mem_gnt_i = 1'b0;
      if (!we) begin
        for (int i = 0; i < rdly; i++) begin
          mem_rvalid_i = 1'b0; mem_rdata_i = $urandom;
          #1 chk("stall_wait", {31'd0, stall_o}, 32'd1);
          @(posedge clk_i); #1;
        end
        mem_rvalid_i = 1'b1; mem_rdata_i = mword;
        @(posedge clk_i); #1;
        mem_rvalid_i = 1'b0; mem_rdata_i = $urandom;
      end
    end
    chk("stall_done", {31'd0, stall_o}, 32'd0);
    start_i = 1'($urandom % 2); mem_rvalid_i = 1'($urandom % 2);
    @(posedge clk_i); #1;
    start_i = 1'b0; mem_rvalid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; start_i = 1'b1; we_i = 1'b1; funct3_i = 3'b010;
    addr_i = 32'h1234_5678; wdata_i = 32'hFFFF_FFFF;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    #12;
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_be", {28'd0, mem_be_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_wdata", mem_wdata_o, 32'd0);
    start_i = 1'b0;
    @(posedge clk_i); #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    run_txn(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, 0);
    run_txn(1'b0, 3'b000, 32'h0000_2001, 32'h0, 32'h0000_8000, 0, 0);
    run_txn(1'b0, 3'b100, 32'h0000_2001, 32'h0, 32'h0000_8000, 1, 2);
    run_txn(1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_0000, 3, 0);
    run_txn(1'b0, 3'b010, 32'h0000_3002, 32'h0, 32'hCAFE_F00D, 0, 1);
    run_txn(1'b1, 3'b101, 32'h0000_3001, 32'h1234_BEEF, 32'h0, 2, 0);

    // Reset in WAIT abandons the load; the late rvalid must be ignored.
    begin
      req_t r;
      r.addr = 32'h0000_4000; r.be = 4'b1111; r.wdata = 32'h0; r.we = 1'b0;
      req_q.push_back(r);
      start_i = 1'b1; we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h0000_4000; wdata_i = 32'h0;
      @(posedge clk_i); #1 start_i = 1'b0; mem_gnt_i = 1'b1;
      @(posedge clk_i); #1 mem_gnt_i = 1'b0;
      chk("stall_wait_pre_rst", {31'd0, stall_o}, 32'd1);
      rst_ni = 1'b0; start_i = 1'b1;
      #2;
      chk("midrst_stall", {31'd0, stall_o}, 32'd0);
      chk("midrst_req", {31'd0, mem_req_o}, 32'd0);
      chk("midrst_rdata", rdata_o, 32'd0);
      @(posedge clk_i); #1 rst_ni = 1'b1; start_i = 1'b0;
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
      @(posedge clk_i); #1 mem_rvalid_i = 1'b0;
      @(posedge clk_i); #1;
      chk("midrst_rdata_after", rdata_o, 32'd0);
      chk("midrst_idle", {31'd0, stall_o | done_o | mem_req_o}, 32'd0);
      last_load = '0;
    end

    for (int n = 0; n < 300; n++)
      run_txn(1'($urandom % 2), 3'($urandom), $urandom, $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3));

    repeat (3) @(posedge clk_i);
    #1;
    chk("done_q_empty", done_q.size(), 32'd0);
    chk("req_q_empty", req_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
